// File: rtl/light_scheduler.sv
// light_scheduler: turns RTC hours/minutes into a ramped LED brightness target.
// A daily on/off window (optionally wrapping midnight) decides whether the
// lights are wanted; brightness then walks toward full-on or off by a fixed
// step on every 1 Hz tick instead of switching abruptly.
module light_scheduler #(
  parameter int STEP      = 64,
  parameter int MAX_LEVEL = 255
) (
  input  logic       i_clk_1hz,
  input  logic       i_rst,
  input  logic [5:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_on_hour,
  input  logic [5:0] i_on_minute,
  input  logic [5:0] i_off_hour,
  input  logic [5:0] i_off_minute,
  input  logic       i_enable,
  input  logic       i_force_on,
  output logic [7:0] o_brightness,
  output logic [1:0] o_state,
  output logic       o_lights_on,
  output logic       o_cfg_err
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [8:0] STEP_9 = 9'(STEP);
  localparam logic [8:0] MAX_9  = 9'(MAX_LEVEL);
  localparam logic [7:0] STEP_8 = 8'(STEP);
  localparam logic [7:0] MAX_8  = 8'(MAX_LEVEL);

  // Minutes since midnight; 11 bits holds 0..1439 for legal inputs.
  function automatic logic [10:0] to_minutes(input logic [5:0] h, input logic [5:0] m);
    return ({5'd0, h} * 11'd60) + {5'd0, m};
  endfunction

  // A time field pair is illegal when hours exceed 23 or minutes exceed 59.
  function automatic logic time_bad(input logic [5:0] h, input logic [5:0] m);
    return (h > 6'd23) || (m > 6'd59);
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  next_b_s;
  logic [10:0] t_now_s;
  logic [10:0] t_on_s;
  logic [10:0] t_off_s;
  logic        cfg_err_s;
  logic        win_s;
  logic        active_s;
  logic [8:0]  sum_s;
  logic [7:0]  up_s;
  logic [7:0]  down_s;

  assign t_now_s   = to_minutes(i_hours, i_minutes);
  assign t_on_s    = to_minutes(i_on_hour, i_on_minute);
  assign t_off_s   = to_minutes(i_off_hour, i_off_minute);
  assign cfg_err_s = time_bad(i_hours, i_minutes) ||
                     time_bad(i_on_hour, i_on_minute) ||
                     time_bad(i_off_hour, i_off_minute);

  // Window membership; an inverted window wraps past midnight, an empty one never matches.
  always_comb begin
    win_s = 1'b0;
    if (t_on_s < t_off_s) begin
      win_s = (t_now_s >= t_on_s) && (t_now_s < t_off_s);
    end else if (t_on_s > t_off_s) begin
      win_s = (t_now_s >= t_on_s) || (t_now_s < t_off_s);
    end else begin
      win_s = 1'b0;
    end
  end

  // Force overrides both the enable and a bad configuration.
  assign active_s = i_force_on || (i_enable && win_s && !cfg_err_s);

  // One step toward full-on (saturating in 9 bits) and toward off (clamped at 0).
  assign sum_s  = {1'b0, o_brightness} + STEP_9;
  assign up_s   = (sum_s > MAX_9) ? MAX_8 : sum_s[7:0];
  assign down_s = (o_brightness >= STEP_8) ? (o_brightness - STEP_8) : 8'd0;

  // Next state and brightness; a direction change costs one tick with no step.
  always_comb begin
    next_state_s = state_r;
    next_b_s     = o_brightness;
    case (state_r)
      ST_OFF: begin
        if (active_s) begin
          next_state_s = ST_RAMP_UP;
        end else begin
          next_state_s = ST_OFF;
        end
      end
      ST_RAMP_UP: begin
        if (!active_s) begin
          next_state_s = ST_RAMP_DOWN;
        end else begin
          next_b_s = up_s;
          if (up_s == MAX_8) begin
            next_state_s = ST_ON;
          end else begin
            next_state_s = ST_RAMP_UP;
          end
        end
      end
      ST_ON: begin
        next_b_s = MAX_8;
        if (!active_s) begin
          next_state_s = ST_RAMP_DOWN;
        end else begin
          next_state_s = ST_ON;
        end
      end
      ST_RAMP_DOWN: begin
        if (active_s) begin
          next_state_s = ST_RAMP_UP;
        end else begin
          next_b_s = down_s;
          if (down_s == 8'd0) begin
            next_state_s = ST_OFF;
          end else begin
            next_state_s = ST_RAMP_DOWN;
          end
        end
      end
      default: begin
        next_state_s = ST_OFF;
        next_b_s     = 8'd0;
      end
    endcase
  end

  // Register FSM state and all outputs; lights_on tracks the brightness being written.
  always_ff @(posedge i_clk_1hz or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_OFF;
      o_brightness <= 8'd0;
      o_lights_on  <= 1'b0;
      o_cfg_err    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      o_brightness <= next_b_s;
      o_lights_on  <= (next_b_s != 8'd0);
      o_cfg_err    <= cfg_err_s;
    end
  end

  assign o_state = state_r;

endmodule

// File: tb/tb_light_scheduler.sv
// Self-checking bench for light_scheduler: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle to a model.
module tb_light_scheduler;
  localparam int STEP = 64;
  localparam int MAXL = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hours = 6'd0, minutes = 6'd0;
  logic [5:0] on_h = 6'd0, on_m = 6'd0, off_h = 6'd0, off_m = 6'd0;
  logic       en = 1'b0, force_on = 1'b0;
  logic [7:0] bright;
  logic [1:0] state;
  logic       lon, cerr;

  int total = 0;
  int bad = 0;

  // Model: brightness level, phase (0 off,1 up,2 on,3 down), flags.
  int m_b = 0, m_st = 0;
  int m_lon = 0, m_cerr = 0;
  int m_err, m_act;

  always #5 clk = ~clk;

  light_scheduler #(.STEP(STEP), .MAX_LEVEL(MAXL)) dut (
    .i_clk_1hz(clk), .i_rst(rst),
    .i_hours(hours), .i_minutes(minutes),
    .i_on_hour(on_h), .i_on_minute(on_m),
    .i_off_hour(off_h), .i_off_minute(off_m),
    .i_enable(en), .i_force_on(force_on),
    .o_brightness(bright), .o_state(state),
    .o_lights_on(lon), .o_cfg_err(cerr)
  );

  // Window as modular distance: t is inside when it lies fewer minutes past
  // t_on than t_off does (empty window when equal).
  function automatic int in_win(int t, int a, int b);
    return (((t - a + 1440) % 1440) < ((b - a + 1440) % 1440)) ? 1 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model advanced on each clock edge, cleared by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b = 0; m_st = 0; m_lon = 0; m_cerr = 0;
    end else begin
      m_err = (hours > 23 || minutes > 59 || on_h > 23 || on_m > 59 ||
               off_h > 23 || off_m > 59) ? 1 : 0;
      m_act = 0;
      if (force_on) m_act = 1;
      else if (en && !m_err &&
               in_win(hours * 60 + minutes, on_h * 60 + on_m, off_h * 60 + off_m) == 1)
        m_act = 1;
      m_cerr = m_err;
      if (m_st == 0) begin
        if (m_act == 1) m_st = 1;
      end else if (m_st == 1) begin
        if (m_act == 0) m_st = 3;
        else begin
          m_b = (m_b + STEP > MAXL) ? MAXL : m_b + STEP;
          if (m_b == MAXL) m_st = 2;
        end
      end else if (m_st == 2) begin
        if (m_act == 0) m_st = 3;
      end else begin
        if (m_act == 1) m_st = 1;
        else begin
          m_b = (m_b - STEP < 0) ? 0 : m_b - STEP;
          if (m_b == 0) m_st = 0;
        end
      end
      m_lon = (m_b != 0) ? 1 : 0;
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    check("model_bright", bright, m_b);
    check("model_state", state, m_st);
    check("model_lights_on", lon, m_lon);
    check("model_cfg_err", cerr, m_cerr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bs(string name, int b, int s);
    check({name, "_b"}, bright, b);
    check({name, "_st"}, state, s);
  endtask

  task automatic set_time(int h, int m);
    hours = 6'(h);
    minutes = 6'(m);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  typedef struct { int h; int m; int exp; } wpt_t;
  wpt_t wpts[7];

  initial begin
    #1 rst = 1'b1;
    on_h = 6'd7; on_m = 6'd0; off_h = 6'd8; off_m = 6'd0; en = 1'b1;
    set_time(6, 59);
    #12 rst = 1'b0;

    // Pin the model's window rule with hand-computed points.
    check("pin_win_2359", in_win(23 * 60 + 59, 22 * 60 + 30, 6 * 60 + 15), 1);
    check("pin_win_0615", in_win(6 * 60 + 15, 22 * 60 + 30, 6 * 60 + 15), 0);
    check("pin_win_equal", in_win(600, 600, 600), 0);

    // Ramp up into the 07:00-08:00 window.
    tick(); expect_bs("pre_window", 0, 0);
    check("reset_lights_on", lon, 0);
    set_time(7, 0);
    tick(); expect_bs("up0", 0, 1);
    tick(); expect_bs("up64", 64, 1);
    tick(); expect_bs("up128", 128, 1);
    tick(); expect_bs("up192", 192, 1);
    tick(); expect_bs("up255", 255, 2);
    check("on_lights", lon, 1);

    // Leave the window and ramp down.
    set_time(8, 0);
    tick(); expect_bs("dn255", 255, 3);
    tick(); expect_bs("dn191", 191, 3);
    tick(); expect_bs("dn127", 127, 3);
    tick(); expect_bs("dn63", 63, 3);
    check("dn63_lights", lon, 1);
    tick(); expect_bs("dn0", 0, 0);
    check("off_lights", lon, 0);

    // Mid-ramp reversals keep the current level.
    set_time(7, 0);
    tick(); expect_bs("r_up0", 0, 1);
    tick(); expect_bs("r_up64", 64, 1);
    tick(); expect_bs("r_up128", 128, 1);
    set_time(8, 0);
    tick(); expect_bs("r_hold128", 128, 3);
    tick(); expect_bs("r_dn64", 64, 3);
    tick(); expect_bs("r_dn0", 0, 0);
    set_time(7, 0);
    tick(); tick(); tick(); tick(); expect_bs("r2_up192", 192, 1);
    set_time(8, 0);
    tick(); tick(); tick(); expect_bs("r2_dn64", 64, 3);
    set_time(7, 0);
    tick(); expect_bs("r2_hold64", 64, 1);
    tick(); expect_bs("r2_up128", 128, 1);

    // Bad minutes inside the window: error flag, ramp down, then force wins.
    minutes = 6'd60;
    tick(); expect_bs("err_hold", 128, 3);
    check("err_flag", cerr, 1);
    tick(); tick(); expect_bs("err_off", 0, 0);
    tick(); expect_bs("err_stay_off", 0, 0);
    force_on = 1'b1;
    tick(); expect_bs("force_up0", 0, 1);
    check("force_err_flag", cerr, 1);
    tick(); expect_bs("force_up64", 64, 1);
    force_on = 1'b0; minutes = 6'd0;
    tick(); tick(); expect_bs("pre_rst192", 192, 1);
    check("err_cleared", cerr, 0);

    // Asynchronous reset mid-ramp, then release inside the window.
    #1 rst = 1'b1;
    #1 expect_bs("async_rst", 0, 0);
    check("async_rst_lights", lon, 0);
    rst = 1'b0;
    tick(); expect_bs("post_rst", 0, 1);

    // Midnight-wrapping window and empty window.
    on_h = 6'd22; on_m = 6'd30; off_h = 6'd6; off_m = 6'd15;
    wpts[0] = '{23, 59, 1}; wpts[1] = '{0, 0, 1}; wpts[2] = '{6, 14, 1};
    wpts[3] = '{6, 15, 0}; wpts[4] = '{12, 0, 0};
    wpts[5] = '{10, 0, 0}; wpts[6] = '{15, 0, 0};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        on_h = 6'd10; on_m = 6'd0; off_h = 6'd10; off_m = 6'd0;
      end
      pulse_reset();
      set_time(wpts[i].h, wpts[i].m);
      tick();
      check($sformatf("win_pt%0d", i), state, wpts[i].exp);
    end

    // Randomized segments: hold a random configuration for a few ticks.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      if ($urandom_range(0, 2) == 0) begin
        on_h = 6'($urandom_range(0, 23)); on_m = 6'($urandom_range(0, 59));
        off_h = 6'($urandom_range(0, 23)); off_m = 6'($urandom_range(0, 59));
      end
      hours = 6'($urandom_range(0, 24));
      minutes = 6'($urandom_range(0, 60));
      if ($urandom_range(0, 29) == 0) on_m = 6'($urandom_range(60, 63));
      if ($urandom_range(0, 5) == 0) begin
        hours = on_h; minutes = on_m;
      end
      en = ($urandom_range(0, 3) != 0);
      force_on = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) tick();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
